// File: rtl/sram_bus_arbiter_if.sv
// Pipeline-facing request/ack ports and board SRAM pins of the shared SRAM arbiter.
// The arbiter takes the slave view; the pipeline/board side takes the master view.
interface sram_bus_arbiter_if #(
    parameter int ADDR_W = 20
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_ack;
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_ack;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              ram_ce_n;
    logic              ram_oe_n;
    logic              ram_we_n;
    logic [3:0]        ram_be_n;
    logic              stall_if;
    logic              stall_mem;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata,
        output if_rdata, if_ack, d_rdata, d_ack, ram_addr, ram_wdata,
               ram_ce_n, ram_oe_n, ram_we_n, ram_be_n, stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata,
        input  if_rdata, if_ack, d_rdata, d_ack, ram_addr, ram_wdata,
               ram_ce_n, ram_oe_n, ram_we_n, ram_be_n, stall_if, stall_mem
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Shares one async SRAM between the IF (read-only) and MEM (read/write) ports.
// Latency: ack WAIT_CYCLES+1 cycles after req is sampled; grants spaced WAIT_CYCLES+2 apart.
// Backpressure: req held until ack, stall_if/stall_mem flag waiting ports; ARB_FAIR_EN alternates grants.
module sram_bus_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    sram_bus_arbiter_if.slave bus
);
    localparam int               CNT_W    = $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              grant_d, grant_i, grant;
    logic              own_d, lat_we, sel_we;
    logic [3:0]        lat_be, sel_be;

    logic              ce_n_q, oe_n_q, we_n_q, if_ack_q, d_ack_q;
    logic              ce_n_nxt, oe_n_nxt, we_n_nxt, if_ack_nxt, d_ack_nxt;
    logic [3:0]        be_n_q, be_n_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, if_rdata_q, d_rdata_q, if_rdata_nxt, d_rdata_nxt;

`ifdef ARB_FAIR_EN
    logic last_d;

    always_ff @(posedge clk) begin
        if (rst)        last_d <= 1'b0;
        else if (grant) last_d <= grant_d;
    end

    // On contention the port that did not own the previous access wins.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE) begin
            if (bus.d_req && bus.if_req) begin
                grant_d = ~last_d;
                grant_i = last_d;
            end else begin
                grant_d = bus.d_req;
                grant_i = bus.if_req;
            end
        end
    end
`else
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE) begin
            grant_d = bus.d_req;
            grant_i = bus.if_req & ~bus.d_req;
        end
    end
`endif

    assign grant = grant_d | grant_i;

    // Attributes of the access being started this edge, or of the one in flight.
    always_comb begin
        sel_we = lat_we;
        sel_be = lat_be;
        if (grant_d) begin
            sel_we = bus.d_we;
            sel_be = bus.d_be;
        end else if (grant_i) begin
            sel_we = 1'b0;
            sel_be = 4'hF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = '0;
                end
            end
            ACCESS: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered pins; write enable waits one cycle for address setup.
    always_comb begin
        ce_n_nxt     = 1'b1;
        oe_n_nxt     = 1'b1;
        we_n_nxt     = 1'b1;
        be_n_nxt     = 4'hF;
        if_ack_nxt   = 1'b0;
        d_ack_nxt    = 1'b0;
        if_rdata_nxt = if_rdata_q;
        d_rdata_nxt  = d_rdata_q;
        if (state_nxt == ACCESS) begin
            ce_n_nxt = 1'b0;
            oe_n_nxt = sel_we;
            we_n_nxt = ~(sel_we && (cnt_nxt != '0));
            be_n_nxt = sel_we ? ~sel_be : 4'h0;
        end
        if (state == ACCESS && state_nxt == DONE) begin
            if (own_d) begin
                d_ack_nxt = 1'b1;
                if (!lat_we) d_rdata_nxt = bus.ram_rdata;
            end else begin
                if_ack_nxt   = 1'b1;
                if_rdata_nxt = bus.ram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            be_n_q     <= 4'hF;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            own_d      <= 1'b0;
            lat_we     <= 1'b0;
            lat_be     <= 4'h0;
        end else begin
            ce_n_q     <= ce_n_nxt;
            oe_n_q     <= oe_n_nxt;
            we_n_q     <= we_n_nxt;
            be_n_q     <= be_n_nxt;
            if_ack_q   <= if_ack_nxt;
            d_ack_q    <= d_ack_nxt;
            if_rdata_q <= if_rdata_nxt;
            d_rdata_q  <= d_rdata_nxt;
            if (grant) begin
                own_d   <= grant_d;
                lat_we  <= sel_we;
                lat_be  <= sel_be;
                addr_q  <= grant_d ? bus.d_addr[ADDR_W+1:2] : bus.if_addr[ADDR_W+1:2];
                wdata_q <= grant_d ? bus.d_wdata : 32'h0;
            end
        end
    end

    assign bus.ram_ce_n  = ce_n_q;
    assign bus.ram_oe_n  = oe_n_q;
    assign bus.ram_we_n  = we_n_q;
    assign bus.ram_be_n  = be_n_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.stall_if  = bus.if_req & ~if_ack_q;
    assign bus.stall_mem = bus.d_req & ~d_ack_q;
endmodule
